// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: serializes whole cache-line reads and writebacks into
// fixed-width memory bursts and pulses pmem_resp once the line completes.
module cacheline_burst_adapter #(
    parameter int S_OFFSET = 5,
    parameter int S_LINE   = 8 * (2 ** S_OFFSET),
    parameter int S_BURST  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [31:0]        pmem_address,
    input  logic [S_LINE-1:0]  pmem_wdata,
    output logic [S_LINE-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic               mem_read,
    output logic               mem_write,
    output logic [31:0]        mem_address,
    output logic [S_BURST-1:0] mem_wdata,
    input  logic [S_BURST-1:0] mem_rdata,
    input  logic               mem_resp
);
    localparam int BEATS = S_LINE / S_BURST;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [31:0] OFF_MASK = (32'd1 << S_OFFSET) - 32'd1;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [S_LINE-1:0] line_buf;
    logic [S_LINE-1:0] rd_line;

    // One buffer holds the latched writeback line or the read line being assembled.
    always_comb begin
        rd_line = line_buf;
        rd_line[cnt*S_BURST +: S_BURST] = mem_rdata;
    end

    assign mem_wdata = mem_write ? line_buf[cnt*S_BURST +: S_BURST] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            line_buf    <= '0;
            pmem_rdata  <= '0;
            pmem_resp   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pmem_resp <= 1'b0;
                    if (pmem_write) begin
                        line_buf    <= pmem_wdata;
                        mem_address <= pmem_address & ~OFF_MASK;
                        mem_write   <= 1'b1;
                        state       <= WR_BURST;
                    end else if (pmem_read) begin
                        mem_address <= pmem_address & ~OFF_MASK;
                        mem_read    <= 1'b1;
                        state       <= RD_BURST;
                    end
                end
                RD_BURST: if (mem_resp) begin
                    line_buf <= rd_line;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        pmem_rdata <= rd_line;
                        pmem_resp  <= 1'b1;
                        mem_read   <= 1'b0;
                        cnt        <= '0;
                        state      <= DONE;
                    end
                end
                WR_BURST: if (mem_resp) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        pmem_resp <= 1'b1;
                        mem_write <= 1'b0;
                        cnt       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    pmem_resp <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
